// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the divided-clock bank.
// Reset half-periods scale by decades across channels.
package clk_div_pkg;

    localparam int CNT_W  = 32;
    localparam int MAX_CH = 8;

    typedef struct packed {
        logic        pending;
        logic        clk_out;
        logic        tick;
    } ch_status_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active/pending divisor,
// registered square-wave output and rise tick.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CW       = 32,
    parameter logic [CW-1:0]    RST_HALF = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          resync,
    input  logic          wr,
    input  logic [CW-1:0] wr_half,
    output ch_status_t    status
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] h;
    logic [CW-1:0] pend_half;
    logic [CW-1:0] heff;
    logic          pend_q;
    logic          en_q;
    logic          out_q;
    logic          tick_q;
    logic          tc;

    assign heff = (h == '0) ? CW'(1) : h;
    assign tc   = (cnt == heff - CW'(1));

    assign status.pending = pend_q;
    assign status.clk_out = out_q;
    assign status.tick    = tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            h         <= RST_HALF;
            pend_half <= '0;
            pend_q    <= 1'b0;
            en_q      <= 1'b0;
            out_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (!en) begin
                // Idle channel: divisor writes take effect at once.
                cnt    <= '0;
                out_q  <= 1'b0;
                en_q   <= 1'b0;
                pend_q <= 1'b0;
                if (wr) begin
                    h <= wr_half;
                end else if (pend_q) begin
                    h <= pend_half;
                end
            end else begin
                en_q <= 1'b1;
                if (!en_q || resync) begin
                    cnt   <= '0;
                    out_q <= 1'b0;
                    if (pend_q) begin
                        h      <= pend_half;
                        pend_q <= 1'b0;
                    end
                end else if (tc) begin
                    cnt    <= '0;
                    out_q  <= !out_q;
                    tick_q <= !out_q;
                    if (pend_q) begin
                        h      <= pend_half;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                // A write coinciding with TC waits for the following TC.
                if (wr) begin
                    pend_half <= wr_half;
                    pend_q    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent 50%-duty clock dividers with glitch-free
// divisor updates, per-channel enable and global phase resync.
module clk_div_bank #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = clk_div_pkg::CNT_W,
    parameter int BASE_HALF = 25_000,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              resync,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    import clk_div_pkg::*;

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;

    // Out-of-range channel indices read as ready and write nowhere.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [63:0] RST64 = 64'(BASE_HALF) * pow10(i);

        ch_status_t st;

        clk_div_ch #(
            .CW       (CNT_W),
            .RST_HALF (RST64[CNT_W-1:0])
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (ch_en[i]),
            .resync  (resync),
            .wr      (wr[i]),
            .wr_half (cfg_half),
            .status  (st)
        );

        assign pending[i] = st.pending;
        assign clk_out[i] = st.clk_out;
        assign tick[i]    = st.tick;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed and randomized checks of clk_div_bank against a
// deadline-based reference model of each channel.
module tb_clk_div_bank;

    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 32;
    localparam int BASE_HALF = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_half;
    logic        resync;
    logic [3:0]  ch_en;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    always #5 clk = ~clk;

    clk_div_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .BASE_HALF (BASE_HALF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .resync    (resync),
        .ch_en     (ch_en),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    // Model: each channel knows the edge number of its next toggle.
    int unsigned m_h  [NUM_CH];
    int unsigned m_ph [NUM_CH];
    bit          m_p  [NUM_CH];
    bit          m_lv [NUM_CH];
    bit          m_tk [NUM_CH];
    bit          m_on [NUM_CH];
    longint      m_due[NUM_CH];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint eff(int unsigned h);
        return (h == 0) ? 1 : longint'(h);
    endfunction

    function automatic logic [3:0] m_outs();
        logic [3:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_lv[i];
        return v;
    endfunction

    function automatic logic [3:0] m_ticks();
        logic [3:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_tk[i];
        return v;
    endfunction

    function automatic logic m_ready();
        return !m_p[cfg_ch];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_h[i]   = BASE_HALF * (10 ** i);
            m_ph[i]  = 0;
            m_p[i]   = 0;
            m_lv[i]  = 0;
            m_tk[i]  = 0;
            m_on[i]  = 0;
            m_due[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        acc = cfg_valid && !m_p[cfg_ch];
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            bit w;
            w = acc && (int'(cfg_ch) == i);
            if (!ch_en[i]) begin
                m_lv[i] = 0;
                m_tk[i] = 0;
                m_on[i] = 0;
                if (w) m_h[i] = cfg_half;
                else if (m_p[i]) m_h[i] = m_ph[i];
                m_p[i] = 0;
            end else begin
                if (!m_on[i] || resync) begin
                    if (m_p[i]) begin
                        m_h[i] = m_ph[i];
                        m_p[i] = 0;
                    end
                    m_lv[i]  = 0;
                    m_tk[i]  = 0;
                    m_on[i]  = 1;
                    m_due[i] = cyc + eff(m_h[i]);
                end else if (cyc == m_due[i]) begin
                    m_lv[i] = !m_lv[i];
                    m_tk[i] = m_lv[i];
                    if (m_p[i]) begin
                        m_h[i] = m_ph[i];
                        m_p[i] = 0;
                    end
                    m_due[i] = cyc + eff(m_h[i]);
                end else begin
                    m_tk[i] = 0;
                end
                if (w) begin
                    m_ph[i] = cfg_half;
                    m_p[i]  = 1;
                end
            end
        end
    endtask

    task automatic tick_clk();
        #1;
        chk("cfg_ready", 64'(cfg_ready), 64'(m_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_out", 64'(clk_out), 64'(m_outs()));
        chk("tick", 64'(tick), 64'(m_ticks()));
    endtask

    task automatic idle();
        cfg_valid = 1'b0;
        resync    = 1'b0;
    endtask

    task automatic wait_toggle(int ch, int maxc, output longint at);
        logic prev;
        prev = clk_out[ch];
        at   = -1;
        for (int k = 0; k < maxc; k++) begin
            tick_clk();
            if (clk_out[ch] !== prev) begin
                at = cyc;
                return;
            end
        end
        checks++;
        failures++;
        $error("FAIL wait_toggle ch%0d observed=timeout expected=toggle within %0d", ch, maxc);
    endtask

    task automatic write_cfg(int ch, int unsigned half);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_half  = half;
        tick_clk();
        cfg_valid = 1'b0;
    endtask

    initial begin
        longint     r1[NUM_CH];
        longint     r2[NUM_CH];
        int         nr[NUM_CH];
        int         nt[NUM_CH];
        logic [3:0] prev;
        longint     a, t1, t2, e, s;
        int         k, cnt;

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_half  = '0;
        resync    = 1'b0;
        ch_en     = 4'hF;
        model_reset();

        #12;
        chk("reset_clk_out", 64'(clk_out), 64'h0);
        chk("reset_tick", 64'(tick), 64'h0);
        chk("reset_ready", 64'(cfg_ready), 64'h1);

        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Reset periods: 4/40/400/4000 cycles with one tick per period.
        for (int i = 0; i < NUM_CH; i++) begin
            r1[i] = -1;
            r2[i] = -1;
            nr[i] = 0;
            nt[i] = 0;
        end
        for (int n = 0; n < 6010; n++) begin
            prev = clk_out;
            tick_clk();
            for (int i = 0; i < NUM_CH; i++) begin
                if (!prev[i] && clk_out[i]) begin
                    if (r1[i] < 0) r1[i] = cyc;
                    else if (r2[i] < 0) r2[i] = cyc;
                    nr[i]++;
                end
                if (tick[i]) nt[i]++;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("first_rise%0d", i), 64'(r1[i]),
                64'(1 + BASE_HALF * (10 ** i)));
            chk($sformatf("period%0d", i), 64'(r2[i] - r1[i]),
                64'(2 * BASE_HALF * (10 ** i)));
            chk($sformatf("ticks_per_rise%0d", i), 64'(nt[i]), 64'(nr[i]));
        end

        // ch0 H=5 written two cycles before TC.
        k = 0;
        while (m_due[0] != cyc + 2 && k < 20) begin
            tick_clk();
            k++;
        end
        write_cfg(0, 5);
        a = cyc;
        #1;
        chk("ch0_ready_pending", 64'(cfg_ready), 64'h0);
        wait_toggle(0, 20, t1);
        chk("ch0_tc_on_time", 64'(t1), 64'(a + 1));
        wait_toggle(0, 20, t2);
        chk("ch0_half5", 64'(t2 - t1), 64'd5);
        #1;
        chk("ch0_ready_after", 64'(cfg_ready), 64'h1);

        // ch1 H=0 -> toggle every cycle after the next TC.
        write_cfg(1, 0);
        wait_toggle(1, 50, t1);
        cnt = 0;
        k   = 0;
        for (int n = 0; n < 8; n++) begin
            prev = clk_out;
            tick_clk();
            if (prev[1] !== clk_out[1]) k++;
            if (tick[1]) cnt++;
        end
        chk("ch1_toggles", 64'(k), 64'd8);
        chk("ch1_ticks", 64'(cnt), 64'd4);

        // ch0 H=2, then write 7 coincident with a TC.
        write_cfg(0, 2);
        wait_toggle(0, 20, t1);
        k = 0;
        while (m_due[0] != cyc + 1 && k < 20) begin
            tick_clk();
            k++;
        end
        write_cfg(0, 7);
        e = cyc;
        wait_toggle(0, 20, t1);
        chk("ch0_one_more_2", 64'(t1 - e), 64'd2);
        wait_toggle(0, 20, t2);
        chk("ch0_then_7", 64'(t2 - t1), 64'd7);

        // resync during ch2 high phase with pending H=3.
        k = 0;
        while (!(clk_out[2] === 1'b1 && m_due[2] > cyc + 5) && k < 1000) begin
            tick_clk();
            k++;
        end
        write_cfg(2, 3);
        resync = 1'b1;
        tick_clk();
        resync = 1'b0;
        s = cyc;
        chk("resync_clk_out", 64'(clk_out), 64'h0);
        chk("resync_tick", 64'(tick), 64'h0);
        cfg_ch = 2'd2;
        #1;
        chk("resync_ch2_ready", 64'(cfg_ready), 64'h1);
        wait_toggle(2, 20, t1);
        chk("resync_ch2_rise", 64'(t1 - s), 64'd3);

        // ch3 disabled for 10 cycles, immediate write, then re-enable.
        ch_en[3] = 1'b0;
        tick_clk();
        write_cfg(3, 6);
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            tick_clk();
            if (clk_out[3] !== 1'b0) cnt++;
        end
        chk("ch3_low_disabled", 64'(cnt), 64'd0);
        cfg_ch = 2'd3;
        #1;
        chk("ch3_ready_disabled", 64'(cfg_ready), 64'h1);
        ch_en[3] = 1'b1;
        tick_clk();
        s = cyc;
        wait_toggle(3, 20, t1);
        chk("ch3_first_rise", 64'(t1 - s), 64'd6);

        // Asynchronous reset mid-period discards a pending write.
        k = 0;
        while (m_p[0] && k < 50) begin
            tick_clk();
            k++;
        end
        write_cfg(0, 9);
        k = 0;
        while (clk_out === 4'h0 && k < 50) begin
            tick_clk();
            k++;
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_out", 64'(clk_out), 64'h0);
        chk("async_rst_tick", 64'(tick), 64'h0);
        cfg_ch = 2'd0;
        #1;
        chk("async_rst_ready", 64'(cfg_ready), 64'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        wait_toggle(0, 10, t1);
        chk("post_rst_ch0_rise", 64'(t1), 64'(1 + BASE_HALF));

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 600; n++) begin
            cfg_valid = ($urandom % 3) == 0;
            cfg_ch    = 2'($urandom % 4);
            cfg_half  = $urandom_range(0, 9);
            resync    = ($urandom % 40) == 0;
            if (($urandom % 50) == 0) ch_en = 4'($urandom);
            tick_clk();
        end
        idle();
        tick_clk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent divider channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the half-period counter width.
REQ-003 The block SHALL have parameter BASE_HALF, default 25_000, meaning the reset half-period of channel 0; channel i resets to BASE_HALF*10^i.
REQ-004 The block SHALL have port clk, input, 1, the system clock.
REQ-005 The block SHALL have port rst_n, input, 1; there is one clock, and reset is asynchronous and active-low.
REQ-006 The block SHALL have port cfg_valid, input, 1, meaning a divisor-update request.
REQ-007 The block SHALL have port cfg_ready, output, 1, meaning the selected channel can accept an update.
REQ-008 The block SHALL have port cfg_ch, input, max(1,clog2(NUM_CH)), meaning the target channel index.
REQ-009 The block SHALL have port cfg_half, input, CNT_W, meaning the new half-period in clk cycles.
REQ-010 The block SHALL have port resync, input, 1, a single-cycle phase-realign strobe.
REQ-011 The block SHALL have port ch_en, input, NUM_CH, a per-channel enable.
REQ-012 The block SHALL have port clk_out, output, NUM_CH, the registered 50%-duty divided square waves.
REQ-013 The block SHALL have port tick, output, NUM_CH, a one-cycle pulse per channel period.

Function
REQ-014 Each enabled channel SHALL count 0..H-1, where H is its active half-period; at count H-1 it SHALL toggle clk_out, reset count to 0, and advance the half-period counter (terminal count, TC).
REQ-015 H=0 SHALL be treated as H=1, so clk_out toggles every cycle (f_clk/2).
REQ-016 tick[i] SHALL be high for exactly the one cycle in which clk_out[i] rises, registered and coincident with the rising clk_out.
REQ-017 A cfg accept (cfg_valid && cfg_ready) SHALL store cfg_half into channel cfg_ch's pending register and set that channel's pending flag.
REQ-018 cfg_ready SHALL be combinational and equal to !pending[cfg_ch]; cfg_ch >= NUM_CH SHALL drive cfg_ready=1 and the write SHALL be discarded.
REQ-019 A pending value SHALL load into H at the channel's next TC and clear the pending flag, so no output half-period is truncated or stretched.
REQ-020 An accept in the same cycle as the channel's TC SHALL NOT affect that TC; it SHALL apply at the following TC.
REQ-021 On a disabled channel, an accept SHALL load H immediately on the next edge with no pending state.
REQ-022 ch_en[i]=0 SHALL hold count at 0, drive clk_out[i]=0 and tick[i]=0 from the next edge.
REQ-023 On a 0->1 transition of ch_en[i], the first clk_out rise SHALL occur H cycles after the first enabled edge.
REQ-024 resync=1 SHALL, on the next edge, set count=0 and clk_out=0 on all enabled channels and apply any pending values; resync SHALL take priority over a coincident TC and SHALL produce no tick.
REQ-025 All counter arithmetic SHALL be CNT_W-bit unsigned, and the count SHALL never exceed H-1; a new H smaller than the current count cannot occur because loads happen only at TC, resync or while disabled.

Reset
REQ-026 On rst_n=0 (asynchronous), the block SHALL set count=0, clk_out=0, tick=0 and pending=0 on all channels, and set H[i]=BASE_HALF*10^i truncated to CNT_W.
REQ-027 After reset deassertion, the first rise on channel i SHALL occur H[i] cycles after the first edge with rst_n=1 and ch_en[i]=1.
REQ-028 A reset mid-period SHALL discard all pending updates.

Structure
REQ-029 Package clk_div_pkg SHALL hold CNT_W, the NUM_CH maximum, and a pow10 constant function used for the reset half-periods.
REQ-030 Sub-module clk_div_ch SHALL implement one channel (counter, H, pending register, clk_out and tick); clk_div_bank SHALL instantiate NUM_CH copies via generate and own the cfg decode.

Verification (NUM_CH=4, BASE_HALF=2)
REQ-031 Reset release with all ch_en=1 -> clk_out periods SHALL be 4/40/400/4000 cycles, with one tick per period on each channel.
REQ-032 Write ch0 H=5 mid-period, with TC 2 cycles away -> the current half-period SHALL end on time, the next SHALL be 5 cycles, and cfg_ready(ch0) SHALL be low in between.
REQ-033 Write ch1 H=0 -> after the next TC, clk_out[1] SHALL toggle every cycle and tick[1] SHALL pulse every 2 cycles.
REQ-034 Accept coincident with the ch0 TC (H=2 -> 7) -> one more half-period of 2 cycles, then 7.
REQ-035 resync asserted during a ch2 high phase together with a pending ch2 H=3 -> next edge clk_out=0, no tick, first rise 3 cycles later.
REQ-036 ch_en[3]=0 for 10 cycles then 1 -> output SHALL be low throughout, with the first rise H cycles after re-enable; also assert rst_n low mid-period -> all outputs 0 immediately.
